latch_write_seq: RTL and testbench

- Sequencer that drives the gated NAND D-latch (latchDasync) and consumes its outputs.
- Accepts one data bit per valid/ready request and places it on D.
- Applies a timed Enable pulse with setup and hold margins around it.
- Synchronises Qa/Qb back into the clock domain, checks that the latch captured the bit, and reports pass/fail with a saturating error counter.

---
 rtl/latch_write_seq.sv | 181 ++++++++++++++++++
 tb/tb_latch_write_seq.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/latch_write_seq.sv
// rtl/latch_write_seq.sv - write sequencer for a gated D-latch with capture check (optional retry: LATCH_WRITE_SEQ_RETRY_EN)
module latch_write_seq #(
  parameter int SETUP_CYC   = 2,
  parameter int PULSE_CYC   = 3,
  parameter int HOLD_CYC    = 2,
  parameter int SYNC_STAGES = 2,
  parameter int CNT_W       = 4
) (
  input  logic       Clock,
  input  logic       Resetn,
  input  logic       ReqValid,
  input  logic       ReqData,
  output logic       ReqReady,
  output logic       D,
  output logic       Enable,
  input  logic       Qa,
  input  logic       Qb,
  output logic       DoneValid,
  output logic       DoneOk,
  output logic [7:0] ErrCount
);

  // Phase lengths below the usable minimum are clamped rather than rejected.
  localparam int SETUP_N = (SETUP_CYC < 1) ? 1 : SETUP_CYC;
  localparam int PULSE_N = (PULSE_CYC < 1) ? 1 : PULSE_CYC;
  localparam int HOLD_N  = (HOLD_CYC < 1) ? 1 : HOLD_CYC;
  localparam int SYNC_N  = (SYNC_STAGES < 2) ? 2 : SYNC_STAGES;

  localparam logic [CNT_W-1:0] SETUP_LAST = CNT_W'(SETUP_N - 1);
  localparam logic [CNT_W-1:0] PULSE_LAST = CNT_W'(PULSE_N - 1);
  localparam logic [CNT_W-1:0] HOLD_LAST  = CNT_W'(HOLD_N - 1);
  localparam logic [CNT_W-1:0] SYNC_LAST  = CNT_W'(SYNC_N - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETUP,
    S_PULSE,
    S_HOLD,
    S_CHECK,
    S_DONE
  } state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               d_q, d_d;
  logic [7:0]         err_q, err_d;
  logic               done_ok_d;
  logic               ok;
  logic [SYNC_N-1:0]  qa_sync, qb_sync;
  logic               qa_s, qb_s;
`ifdef LATCH_WRITE_SEQ_RETRY_EN
  logic               retry_q, retry_d;
`endif

  assign qa_s     = qa_sync[SYNC_N-1];
  assign qb_s     = qb_sync[SYNC_N-1];
  assign D        = d_q;
  assign ErrCount = err_q;

  // Bring the asynchronous latch outputs into the clock domain.
  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      qa_sync <= '0;
      qb_sync <= '0;
    end else begin
      qa_sync <= {qa_sync[SYNC_N-2:0], Qa};
      qb_sync <= {qb_sync[SYNC_N-2:0], Qb};
    end
  end

  // Next-state logic: each timed phase counts to its last cycle, then hands off.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    d_d       = d_q;
    err_d     = err_q;
    done_ok_d = 1'b0;
    ok        = (qa_s == d_q) && (qb_s == ~d_q);
`ifdef LATCH_WRITE_SEQ_RETRY_EN
    retry_d   = retry_q;
`endif
    case (state_q)
      S_IDLE: begin
`ifdef LATCH_WRITE_SEQ_RETRY_EN
        retry_d = 1'b0;
`endif
        if (ReqValid && ReqReady) begin
          d_d     = ReqData;
          cnt_d   = '0;
          state_d = S_SETUP;
        end
      end
      S_SETUP: begin
        if (cnt_q == SETUP_LAST) begin
          cnt_d   = '0;
          state_d = S_PULSE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_PULSE: begin
        if (cnt_q == PULSE_LAST) begin
          cnt_d   = '0;
          state_d = S_HOLD;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_HOLD: begin
        if (cnt_q == HOLD_LAST) begin
          cnt_d   = '0;
          state_d = S_CHECK;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_CHECK: begin
        if (cnt_q == SYNC_LAST) begin
          cnt_d = '0;
`ifdef LATCH_WRITE_SEQ_RETRY_EN
          if (!ok && !retry_q) begin
            retry_d = 1'b1;
            state_d = S_SETUP;
          end else begin
`else
          begin
`endif
            state_d   = S_DONE;
            done_ok_d = ok;
            if (!ok && (err_q != 8'hFF)) begin
              err_d = err_q + 8'd1;
            end
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State, data and all outputs are registered from the next-state values.
  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      d_q       <= 1'b0;
      err_q     <= 8'd0;
      Enable    <= 1'b0;
      ReqReady  <= 1'b0;
      DoneValid <= 1'b0;
      DoneOk    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      d_q       <= d_d;
      err_q     <= err_d;
      Enable    <= (state_d == S_PULSE);
      ReqReady  <= (state_d == S_IDLE);
      DoneValid <= (state_d == S_DONE);
      DoneOk    <= done_ok_d;
    end
  end

`ifdef LATCH_WRITE_SEQ_RETRY_EN
  // One retry per request; cleared whenever the sequencer is idle.
  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      retry_q <= 1'b0;
    end else begin
      retry_q <= retry_d;
    end
  end
`endif

endmodule

// File: tb/tb_latch_write_seq.sv
// tb/tb_latch_write_seq.sv - scoreboard bench for latch_write_seq with a behavioural latch
module tb_latch_write_seq;

`ifdef LATCH_WRITE_SEQ_RETRY_EN
  localparam bit RETRY = 1'b1;
`else
  localparam bit RETRY = 1'b0;
`endif

  logic       Clock;
  logic       Resetn;
  logic       ReqValid;
  logic       ReqData;
  logic       ReqReady;
  logic       D;
  logic       Enable;
  logic       Qa;
  logic       Qb;
  logic       DoneValid;
  logic       DoneOk;
  logic [7:0] ErrCount;

  latch_write_seq dut (
    .Clock    (Clock),
    .Resetn   (Resetn),
    .ReqValid (ReqValid),
    .ReqData  (ReqData),
    .ReqReady (ReqReady),
    .D        (D),
    .Enable   (Enable),
    .Qa       (Qa),
    .Qb       (Qb),
    .DoneValid(DoneValid),
    .DoneOk   (DoneOk),
    .ErrCount (ErrCount)
  );

  typedef struct {
    logic data;
    logic ok;
    int   a;
    int   lat;
    int   pulses;
  } exp_t;

  exp_t sb[$];
  exp_t cur;
  int   n_cmp = 0;
  int   n_err = 0;
  int   cyc = 0;
  int   done_count = 0;
  int   err_model = 0;
  int   pulses = 0;
  int   en_w = 0;
  logic en_prev = 1'b0;
  logic busy = 1'b0;
  logic stuck = 1'b0;
  logic lq = 1'b0;

  initial begin
    Clock = 1'b0;
    forever #5 Clock = ~Clock;
  end

  always @(posedge Clock) cyc <= cyc + 1;

  // Behavioural gated D-latch, with an optional Qa stuck-at-0 fault.
  always @(Enable or D) if (Enable) lq = D;
  assign Qa = stuck ? 1'b0 : lq;
  assign Qb = ~lq;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Monitor: accepts push expectations, DoneValid pops and compares.
  always @(negedge Clock) begin
    if (!Resetn) begin
      sb.delete();
      err_model = 0;
      busy      = 1'b0;
      pulses    = 0;
      en_w      = 0;
      en_prev   = 1'b0;
    end else begin
      if (Enable) begin
        if (!en_prev) check_eq("en_rise_cycle", cyc - cur.a + 1, (pulses == 0) ? 3 : 12);
        en_w++;
      end else if (en_prev) begin
        check_eq("en_width", en_w, 3);
        pulses++;
        en_w = 0;
      end
      en_prev = Enable;
      if (busy && cyc == cur.a) check_eq("d_cycle1", D, cur.data);
      if (DoneValid) begin
        if (sb.size() == 0) begin
          check_eq("spurious_done", 1, 0);
        end else begin
          exp_t e;
          e = sb.pop_front();
          if (!e.ok && err_model < 255) err_model++;
          check_eq("done_ok", DoneOk, e.ok);
          check_eq("latency", cyc - e.a + 1, e.lat);
          check_eq("pulses", pulses, e.pulses);
          check_eq("err_count", ErrCount, err_model);
          check_eq("d_at_done", D, e.data);
          busy = 1'b0;
          done_count++;
        end
      end
      if (ReqValid && ReqReady) begin
        cur.data   = ReqData;
        cur.ok     = !(stuck && ReqData);
        cur.a      = cyc + 1;
        cur.lat    = (cur.ok || !RETRY) ? 10 : 19;
        cur.pulses = (cur.ok || !RETRY) ? 1 : 2;
        sb.push_back(cur);
        busy   = 1'b1;
        pulses = 0;
        en_w   = 0;
      end
    end
  end

  task automatic wait_ready();
    int n = 0;
    while (!ReqReady && n < 100) begin
      @(posedge Clock); #1;
      n++;
    end
    if (!ReqReady) check_eq("ready_timeout", 0, 1);
  endtask

  task automatic write_one(input logic data);
    wait_ready();
    ReqValid = 1'b1;
    ReqData  = data;
    @(posedge Clock); #1;
    ReqValid = 1'b0;
  endtask

  task automatic wait_done(input int target, input int budget);
    int n = 0;
    while (done_count < target && n < budget) begin
      @(posedge Clock); #1;
      n++;
    end
    check_eq("done_count", done_count, target);
  endtask

  initial begin
    int a1;
    int a2;
    int n;
    int target;
    Resetn   = 1'b0;
    ReqValid = 1'b0;
    ReqData  = 1'b0;
    repeat (3) @(posedge Clock);
    #1;
    check_eq("rst_ready", ReqReady, 0);
    check_eq("rst_d", D, 0);
    check_eq("rst_enable", Enable, 0);
    check_eq("rst_done_valid", DoneValid, 0);
    check_eq("rst_done_ok", DoneOk, 0);
    check_eq("rst_err", ErrCount, 0);
    @(negedge Clock);
    Resetn = 1'b1;
    #1;
    check_eq("ready_before_edge", ReqReady, 0);
    @(posedge Clock); #1;
    check_eq("ready_after_release", ReqReady, 1);

    // Single good write of 1.
    write_one(1'b1);
    wait_done(1, 40);
    check_eq("err_after_good", ErrCount, 0);

    // Back-to-back 0 then 1 with ReqValid held high.
    wait_ready();
    ReqValid = 1'b1;
    ReqData  = 1'b0;
    @(posedge Clock); #1;
    a1 = cyc;
    ReqData = 1'b1;
    n = 0;
    while (!ReqReady && n < 50) begin
      @(posedge Clock); #1;
      n++;
    end
    @(posedge Clock); #1;
    a2 = cyc;
    ReqValid = 1'b0;
    check_eq("b2b_gap", a2 - a1, 11);
    wait_done(3, 40);

    // Qa stuck at 0: writing 1 fails, writing 0 still passes.
    stuck = 1'b1;
    write_one(1'b1);
    wait_done(4, 60);
    check_eq("err_after_stuck", ErrCount, 1);
    write_one(1'b0);
    wait_done(5, 60);
    check_eq("err_after_stuck0", ErrCount, 1);
    stuck = 1'b0;

    // Reset pulsed during the Enable pulse.
    write_one(1'b1);
    n = 0;
    while (!Enable && n < 20) begin
      @(posedge Clock); #1;
      n++;
    end
    check_eq("reach_pulse", Enable, 1);
    @(posedge Clock); #2;
    Resetn = 1'b0;
    #1;
    check_eq("mid_rst_enable", Enable, 0);
    check_eq("mid_rst_d", D, 0);
    check_eq("mid_rst_ready", ReqReady, 0);
    repeat (3) @(posedge Clock);
    @(negedge Clock);
    Resetn = 1'b1;
    @(posedge Clock); #1;
    check_eq("mid_rst_ready_after", ReqReady, 1);
    check_eq("mid_rst_err", ErrCount, 0);
    repeat (15) @(posedge Clock);
    #1;
    check_eq("no_done_after_rst", done_count, 5);

    // 300 forced failures: ErrCount saturates at 255.
    stuck    = 1'b1;
    ReqValid = 1'b1;
    ReqData  = 1'b1;
    target   = done_count + 300;
    n = 0;
    while (done_count < target && n < 300 * 21 + 100) begin
      @(posedge Clock); #1;
      n++;
    end
    ReqValid = 1'b0;
    check_eq("sat_done_count", done_count, target);
    repeat (5) @(posedge Clock);
    #1;
    check_eq("sat_err", ErrCount, 255);
    check_eq("sb_empty", sb.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
